// File: rtl/i2c_target_pkg.sv
// i2c_target shared definitions
// FSM states and I2C bit-level constants
package i2c_target_defs;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WR_DATA,
    WR_ACK,
    RD_DATA,
    RD_ACK,
    IGNORE
  } state_t;

  localparam logic I2C_RW_WRITE = 1'b0;
  localparam logic I2C_RW_READ  = 1'b1;
  localparam logic I2C_ACK      = 1'b0;
  localparam logic I2C_NACK     = 1'b1;

endpackage

// File: rtl/i2c_line_filter.sv
// i2c_line_filter: 2-FF synchroniser plus stability filter
// Output follows the line only after FILTER_LEN equal samples
module i2c_line_filter #(
  parameter int FILTER_LEN = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_line,
  output logic o_level
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic [1:0]    r_sync;
  logic [CW-1:0] r_cnt;
  logic          r_level;

  // synchronise, then count consecutive samples differing from level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync  <= 2'b11;
      r_cnt   <= '0;
      r_level <= 1'b1;
    end else begin
      r_sync <= {r_sync[0], i_line};
      if (r_sync[1] == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(FILTER_LEN - 1)) begin
        r_level <= r_sync[1];
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_level = r_level;

endmodule

// File: rtl/i2c_target.sv
// i2c_target: byte-oriented I2C responder with register file
// Bus side and host side share regs; bus write wins on collision
module i2c_target
  import i2c_target_defs::*;
#(
  parameter logic [6:0] TARGET_ADDR = 7'h2A,
  parameter int         NUM_REGS    = 16,
  parameter int         FILTER_LEN  = 4,
  localparam int        PTR_W       = $clog2(NUM_REGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             scl_i,
  input  logic             sda_i,
  output logic             sda_o,
  output logic             sda_t,
  input  logic [PTR_W-1:0] host_addr,
  input  logic             host_wr_en,
  input  logic [7:0]       host_wdata,
  output logic [7:0]       host_rdata,
  output logic             wr_strobe,
  output logic [PTR_W-1:0] wr_addr,
  output logic [7:0]       wr_data,
  output logic             busy
);

  logic w_scl;
  logic w_sda;
  logic r_scl_d;
  logic r_sda_d;
  logic w_scl_rise;
  logic w_scl_fall;
  logic w_start;
  logic w_stop;

  state_t           r_state;
  logic [7:0]       r_shift;
  logic [3:0]       r_bitcnt;
  logic [PTR_W-1:0] r_ptr;
  logic             r_first;
  logic             r_rw;
  logic             r_phase;
  logic             r_sda_t;
  logic             r_busy;
  logic             r_wr_strobe;
  logic [PTR_W-1:0] r_wr_addr;
  logic [7:0]       r_wr_data;
  logic [7:0]       r_regs [NUM_REGS];
  logic [7:0]       r_host_rdata;

  logic [7:0] w_byte;
  logic [7:0] w_rd_byte;
  logic       w_bus_we;

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filt (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_line (scl_i),
    .o_level(w_scl)
  );

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filt (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_line (sda_i),
    .o_level(w_sda)
  );

  // previous filtered levels for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scl_d <= 1'b1;
      r_sda_d <= 1'b1;
    end else begin
      r_scl_d <= w_scl;
      r_sda_d <= w_sda;
    end
  end

  assign w_scl_rise = w_scl & ~r_scl_d;
  assign w_scl_fall = ~w_scl & r_scl_d;
  assign w_start    = w_scl & r_scl_d & r_sda_d & ~w_sda;
  assign w_stop     = w_scl & r_scl_d & ~r_sda_d & w_sda;

  assign w_byte    = {r_shift[6:0], w_sda};
  assign w_rd_byte = r_regs[r_ptr];
  assign w_bus_we  = (r_state == WR_DATA) & w_scl_rise &
                     (r_bitcnt == 4'd7) & ~r_first;

  // protocol FSM with registered bus and strobe outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_shift     <= '0;
      r_bitcnt    <= '0;
      r_ptr       <= '0;
      r_first     <= 1'b0;
      r_rw        <= I2C_RW_WRITE;
      r_phase     <= 1'b0;
      r_sda_t     <= 1'b1;
      r_busy      <= 1'b0;
      r_wr_strobe <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
    end else begin
      r_wr_strobe <= 1'b0;
      if (w_stop) begin
        r_state <= IDLE;
        r_sda_t <= 1'b1;
        r_busy  <= 1'b0;
      end else if (w_start) begin
        r_state  <= ADDR;
        r_bitcnt <= '0;
        r_phase  <= 1'b0;
        r_sda_t  <= 1'b1;
        r_busy   <= 1'b0;
      end else begin
        unique case (r_state)
          ADDR: begin
            if (w_scl_rise) begin
              r_shift <= w_byte;
              if (r_bitcnt == 4'd7) begin
                r_bitcnt <= '0;
                r_rw     <= w_sda;
                r_phase  <= 1'b0;
                r_state  <= (r_shift[6:0] == TARGET_ADDR) ?
                            ADDR_ACK : IGNORE;
              end else begin
                r_bitcnt <= r_bitcnt + 4'd1;
              end
            end
          end
          ADDR_ACK: begin
            if (w_scl_fall) begin
              if (!r_phase) begin
                r_sda_t <= I2C_ACK;
                r_busy  <= 1'b1;
                r_phase <= 1'b1;
              end else begin
                r_phase  <= 1'b0;
                r_bitcnt <= '0;
                if (r_rw == I2C_RW_READ) begin
                  r_sda_t <= w_rd_byte[7];
                  r_shift <= {w_rd_byte[6:0], 1'b0};
                  r_ptr   <= r_ptr + 1'b1;
                  r_state <= RD_DATA;
                end else begin
                  r_sda_t <= 1'b1;
                  r_first <= 1'b1;
                  r_state <= WR_DATA;
                end
              end
            end
          end
          WR_DATA: begin
            if (w_scl_rise) begin
              r_shift <= w_byte;
              if (r_bitcnt == 4'd7) begin
                r_bitcnt <= '0;
                r_phase  <= 1'b0;
                r_state  <= WR_ACK;
                if (r_first) begin
                  r_ptr   <= w_byte[PTR_W-1:0];
                  r_first <= 1'b0;
                end else begin
                  r_wr_strobe <= 1'b1;
                  r_wr_addr   <= r_ptr;
                  r_wr_data   <= w_byte;
                  r_ptr       <= r_ptr + 1'b1;
                end
              end else begin
                r_bitcnt <= r_bitcnt + 4'd1;
              end
            end
          end
          WR_ACK: begin
            if (w_scl_fall) begin
              if (!r_phase) begin
                r_sda_t <= I2C_ACK;
                r_phase <= 1'b1;
              end else begin
                r_sda_t <= 1'b1;
                r_phase <= 1'b0;
                r_state <= WR_DATA;
              end
            end
          end
          RD_DATA: begin
            if (w_scl_rise) begin
              r_bitcnt <= r_bitcnt + 4'd1;
            end else if (w_scl_fall) begin
              if (r_bitcnt == 4'd8) begin
                r_sda_t <= 1'b1;
                r_phase <= 1'b0;
                r_state <= RD_ACK;
              end else begin
                r_sda_t <= r_shift[7];
                r_shift <= {r_shift[6:0], 1'b0};
              end
            end
          end
          RD_ACK: begin
            if (w_scl_rise) begin
              if (w_sda == I2C_NACK) begin
                r_state <= IGNORE;
                r_busy  <= 1'b0;
              end else begin
                r_phase <= 1'b1;
              end
            end else if (w_scl_fall && r_phase) begin
              r_sda_t  <= w_rd_byte[7];
              r_shift  <= {w_rd_byte[6:0], 1'b0};
              r_ptr    <= r_ptr + 1'b1;
              r_bitcnt <= '0;
              r_phase  <= 1'b0;
              r_state  <= RD_DATA;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  // register file: host write first, bus write overrides
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
      r_host_rdata <= '0;
    end else begin
      if (host_wr_en) begin
        r_regs[host_addr] <= host_wdata;
      end
      if (w_bus_we) begin
        r_regs[r_ptr] <= w_byte;
      end
      if (w_bus_we && (r_ptr == host_addr)) begin
        r_host_rdata <= w_byte;
      end else if (host_wr_en) begin
        r_host_rdata <= host_wdata;
      end else begin
        r_host_rdata <= r_regs[host_addr];
      end
    end
  end

  assign sda_o      = 1'b0;
  assign sda_t      = r_sda_t;
  assign busy       = r_busy;
  assign wr_strobe  = r_wr_strobe;
  assign wr_addr    = r_wr_addr;
  assign wr_data    = r_wr_data;
  assign host_rdata = r_host_rdata;

endmodule

// File: tb/tb_i2c_target.sv
// tb_i2c_target: directed bench for i2c_target
// Host-port vector table plus hand-written bus sequences
module tb_i2c_target;

  localparam int Q = 68;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl_i = 1'b1;
  logic       tb_sda = 1'b1;
  logic       sda_i;
  logic       sda_o;
  logic       sda_t;
  logic [3:0] host_addr = '0;
  logic       host_wr_en = 1'b0;
  logic [7:0] host_wdata = '0;
  logic [7:0] host_rdata;
  logic       wr_strobe;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;

  int n_checks = 0;
  int n_fail = 0;

  logic [3:0] log_a[$];
  logic [7:0] log_d[$];
  logic       sda_low_seen = 1'b0;
  logic       busy_seen = 1'b0;

  typedef struct {
    logic       we;
    logic [3:0] a;
    logic [7:0] d;
    logic [7:0] exp;
  } hv_t;

  hv_t hv[7];

  always #5 clk = ~clk;

  assign sda_i = tb_sda & (sda_t | sda_o);

  i2c_target dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .scl_i     (scl_i),
    .sda_i     (sda_i),
    .sda_o     (sda_o),
    .sda_t     (sda_t),
    .host_addr (host_addr),
    .host_wr_en(host_wr_en),
    .host_wdata(host_wdata),
    .host_rdata(host_rdata),
    .wr_strobe (wr_strobe),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy      (busy)
  );

  always @(negedge clk) begin
    if (wr_strobe === 1'b1) begin
      log_a.push_back(wr_addr);
      log_d.push_back(wr_data);
    end
    if (sda_t === 1'b0) sda_low_seen = 1'b1;
    if (busy === 1'b1) busy_seen = 1'b1;
  end

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic wc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic i2c_start();
    tb_sda = 1'b1; wc(Q);
    scl_i = 1'b1;  wc(Q);
    tb_sda = 1'b0; wc(Q);
    scl_i = 1'b0;  wc(Q);
  endtask

  task automatic i2c_stop();
    tb_sda = 1'b0; wc(Q);
    scl_i = 1'b1;  wc(Q);
    tb_sda = 1'b1; wc(2 * Q);
  endtask

  task automatic write_bit(input logic b);
    tb_sda = b;   wc(Q);
    scl_i = 1'b1; wc(2 * Q);
    scl_i = 1'b0; wc(Q);
  endtask

  task automatic read_bit(output logic b);
    tb_sda = 1'b1; wc(Q);
    scl_i = 1'b1;  wc(Q);
    b = sda_i;     wc(Q);
    scl_i = 1'b0;  wc(Q);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(ack);
  endtask

  task automatic read_byte(output logic [7:0] d, input logic ack_b);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    write_bit(ack_b);
  endtask

  task automatic host_write(input logic [3:0] a, input logic [7:0] d);
    host_addr = a; host_wdata = d; host_wr_en = 1'b1;
    wc(1);
    host_wr_en = 1'b0;
  endtask

  task automatic host_read(input logic [3:0] a, output logic [7:0] d);
    host_addr = a; host_wr_en = 1'b0;
    wc(2);
    d = host_rdata;
  endtask

  initial begin
    logic       ack;
    logic       got;
    logic [7:0] rd;
    int         n0;

    hv[0] = '{1'b0, 4'd0,  8'h00, 8'h00};
    hv[1] = '{1'b0, 4'd15, 8'h00, 8'h00};
    hv[2] = '{1'b0, 4'd7,  8'h00, 8'h00};
    hv[3] = '{1'b1, 4'd9,  8'h3C, 8'h3C};
    hv[4] = '{1'b0, 4'd9,  8'h00, 8'h3C};
    hv[5] = '{1'b1, 4'd9,  8'hC3, 8'hC3};
    hv[6] = '{1'b0, 4'd8,  8'h00, 8'h00};

    // reset state
    wc(3);
    check("rst_sda_t", sda_t, 1);
    check("rst_sda_o", sda_o, 0);
    check("rst_busy", busy, 0);
    check("rst_strobe", wr_strobe, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_rdata", host_rdata, 0);
    rst_n = 1'b1;
    wc(20);

    // host port vectors
    for (int i = 0; i < 7; i++) begin
      host_addr = hv[i].a;
      host_wdata = hv[i].d;
      host_wr_en = hv[i].we;
      wc(1);
      host_wr_en = 1'b0;
      wc(1);
      check($sformatf("host_vec%0d", i), host_rdata, hv[i].exp);
    end

    // bus write: ptr 3, then 0xA5, 0x5A
    busy_seen = 1'b0;
    i2c_start();
    write_byte(8'h54, ack); check("wr_ack_addr", ack, 0);
    check("wr_busy", busy, 1);
    write_byte(8'h03, ack); check("wr_ack_ptr", ack, 0);
    write_byte(8'hA5, ack); check("wr_ack_d0", ack, 0);
    write_byte(8'h5A, ack); check("wr_ack_d1", ack, 0);
    i2c_stop();
    check("wr_busy_end", busy, 0);
    check("wr_nstrobe", log_a.size(), 2);
    if (log_a.size() >= 2) begin
      check("wr_s0_addr", log_a[0], 3);
      check("wr_s0_data", log_d[0], 8'hA5);
      check("wr_s1_addr", log_a[1], 4);
      check("wr_s1_data", log_d[1], 8'h5A);
    end
    host_read(4'd3, rd); check("wr_reg3", rd, 8'hA5);
    host_read(4'd4, rd); check("wr_reg4", rd, 8'h5A);

    // combined read with pointer wrap
    host_write(4'd15, 8'h11);
    host_write(4'd0, 8'h22);
    n0 = log_a.size();
    i2c_start();
    write_byte(8'h54, ack); check("rd_ack_addr", ack, 0);
    write_byte(8'h0F, ack); check("rd_ack_ptr", ack, 0);
    i2c_start();
    write_byte(8'h55, ack); check("rd_ack_raddr", ack, 0);
    read_byte(rd, 1'b0); check("rd_byte0", rd, 8'h11);
    read_byte(rd, 1'b1); check("rd_byte1", rd, 8'h22);
    wc(10);
    check("rd_nack_busy", busy, 0);
    check("rd_nack_sda_t", sda_t, 1);
    i2c_stop();
    check("rd_nstrobe", log_a.size(), n0);

    // address mismatch
    n0 = log_a.size();
    sda_low_seen = 1'b0;
    busy_seen = 1'b0;
    i2c_start();
    write_byte(8'h56, ack); check("mm_ack", ack, 1);
    write_byte(8'h12, ack); check("mm_ack_d", ack, 1);
    i2c_stop();
    check("mm_sda_low", sda_low_seen, 0);
    check("mm_busy", busy_seen, 0);
    check("mm_nstrobe", log_a.size(), n0);

    // 2-cycle SDA glitch while SCL high must not START
    wc(20);
    tb_sda = 1'b0;
    repeat (2) @(posedge clk);
    #1 tb_sda = 1'b1;
    wc(40);
    sda_low_seen = 1'b0;
    scl_i = 1'b0; wc(Q);
    write_byte(8'h54, ack); check("gl_no_ack", ack, 1);
    check("gl_sda_low", sda_low_seen, 0);
    i2c_stop();

    // host/bus write collision on reg5
    i2c_start();
    write_byte(8'h54, ack); check("co_ack_addr", ack, 0);
    write_byte(8'h05, ack); check("co_ack_ptr", ack, 0);
    n0 = log_a.size();
    got = 1'b0;
    fork
      begin
        logic a2;
        write_byte(8'h33, a2);
        ack = a2;
      end
      begin
        host_addr = 4'd5; host_wdata = 8'hFF; host_wr_en = 1'b1;
        for (int k = 0; k < 4000 && !got; k++) begin
          @(posedge clk); #1;
          if (wr_strobe === 1'b1) got = 1'b1;
        end
        host_wr_en = 1'b0;
      end
    join
    check("co_strobe_seen", got, 1);
    check("co_ack_d", ack, 0);
    i2c_stop();
    host_read(4'd5, rd); check("co_reg5", rd, 8'h33);
    if (log_a.size() > n0) begin
      check("co_s_addr", log_a[n0], 5);
      check("co_s_data", log_d[n0], 8'h33);
    end

    // reset mid-transfer while driving ACK
    i2c_start();
    for (int i = 7; i >= 0; i--) write_bit(1'(8'h54 >> i));
    check("mr_pre_sda_t", sda_t, 0);
    check("mr_pre_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1 check("mr_async_sda_t", sda_t, 1);
    check("mr_busy", busy, 0);
    wc(3);
    check("mr_strobe", wr_strobe, 0);
    check("mr_wr_addr", wr_addr, 0);
    check("mr_wr_data", wr_data, 0);
    check("mr_rdata", host_rdata, 0);
    scl_i = 1'b1; tb_sda = 1'b1;
    wc(5);
    rst_n = 1'b1;
    wc(20);
    host_read(4'd3, rd); check("mr_reg3", rd, 0);
    host_read(4'd5, rd); check("mr_reg5", rd, 0);
    check("mr_sda_t_idle", sda_t, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_target.md
Name: i2c_target

Overview:
Byte-oriented I2C responder (target) with an internal byte register file, so the FPGA can be addressed by an external I2C controller. It is the bus-side counterpart of the existing I2C controller path, sits beside it in top, and shares the same open-drain tristate pin convention (drive-low or release). Fabric logic reads and writes the same register file through a simple host port, and is notified of every bus write.

Parameters:
- TARGET_ADDR, 7'h2A, 7-bit I2C address this block answers to.
- NUM_REGS, 16, register file depth in bytes; must be a power of two, ≥2.
- FILTER_LEN, 4, cycles a synchronised SCL/SDA level must be stable before it is accepted.

Ports:
- clk  in  1  system clock (27 MHz in top).
- rst_n  in  1  asynchronous, active-low reset.
- scl_i  in  1  SCL pin level.
- sda_i  in  1  SDA pin level.
- sda_o  out  1  SDA drive value; constant 0.
- sda_t  out  1  SDA tristate: 1 = release, 0 = drive sda_o.
- host_addr  in  $clog2(NUM_REGS)  host register index.
- host_wr_en  in  1  host write strobe.
- host_wdata  in  8  host write data.
- host_rdata  out  8  regs[host_addr], registered; 1-cycle latency.
- wr_strobe  out  1  1-cycle pulse per bus-written byte.
- wr_addr  out  $clog2(NUM_REGS)  register index of that byte.
- wr_data  out  8  value written.
- busy  out  1  high from an address match until STOP, repeated START or NACK-idle.

Behaviour:
- Reset values: sda_t=1, sda_o=0, busy=0, wr_strobe=0, wr_addr=0, wr_data=0, host_rdata=0, all regs=0, pointer=0, state IDLE.
- Input conditioning: each line passes through a 2-FF synchroniser, then the filter. Filtered level updates only after FILTER_LEN consecutive identical samples.
- Edge detection (filtered signals only):
  - START = SDA falls while SCL high.
  - STOP = SDA rises while SCL high.
  - Data is sampled on SCL rise; SDA is changed only on SCL fall.
- States:
  - IDLE → ADDR on START.
  - ADDR: shift 8 bits MSB first. After the 8th SCL rise: address match → ADDR_ACK; mismatch → IGNORE.
  - ADDR_ACK: at the next SCL fall, sda_t=0 and busy=1. At the following SCL fall, release SDA. R/W=0 → WR_DATA with first_byte=1. R/W=1 → load shift reg from regs[ptr], ptr++ → RD_DATA.
  - WR_DATA: shift 8 bits, then → WR_ACK, which drives ACK for one SCL low-high-low. First byte after the address sets ptr = byte[PTR_W-1:0]; no strobe. Subsequent bytes write regs[ptr], pulse wr_strobe/wr_addr/wr_data on the cycle after the 8th SCL rise, then ptr++.
  - RD_DATA: drive the shift-reg MSB at each SCL fall (sda_t = bit, since 0 → drive low). After 8 bits, release SDA → RD_ACK.
  - RD_ACK: sample SDA at SCL rise. ACK (0): at SCL fall load regs[ptr], ptr++, → RD_DATA. NACK (1): → IGNORE, busy=0.
  - IGNORE: SDA released; wait for START or STOP.
- Global rules:
  - START in any state → ADDR: bit counter=0, SDA released, ptr retained.
  - STOP in any state → IDLE: release SDA, busy=0.
- Pointer arithmetic: modulo NUM_REGS; ptr=NUM_REGS-1 increments to 0.
- Host port: host write updates regs the cycle after host_wr_en. A host write and a bus write to the same index in the same cycle → the bus write wins. host_rdata reflects a write from the same cycle on the next cycle.
- Read snapshot: a byte is captured into the shift register at load time; later writes do not alter a byte already in transmission.
- No clock stretching; SCL is never driven.
- Reset asserted mid-transfer: SDA released immediately (asynchronous); the transaction is abandoned.

Decomposition:
- Package i2c_target_defs: state_t enum (IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE), I2C_RW_WRITE/I2C_RW_READ constants, ACK/NACK bit constants.
- Sub-module i2c_line_filter: synchroniser plus FILTER_LEN stability filter, with parameter FILTER_LEN and reset level 1. Instantiated once for SCL and once for SDA.

Test Plan:
- Reset with rst_n=0 mid-byte while sda_t=0 → sda_t=1 asynchronously; all outputs at reset values; regs read 0 via the host port.
- Bus write: START, 0x54, ptr 0x03, 0xA5, 0x5A, STOP at 100 kHz (SCL period 270 clk) → ACK on all 4 bytes; wr_strobe pulses (3,0xA5) then (4,0x5A); host_rdata@3=0xA5.
- Combined read: host writes reg15=0x11, reg0=0x22. Bus sends START 0x54 ptr 0x0F, repeated START 0x55, reads 2 bytes ACK then NACK, STOP → bytes 0x11, 0x22 (pointer wraps 15→0); SDA released after NACK; busy falls.
- Address mismatch: START 0x56 … STOP → no ACK, sda_t stays 1 throughout, busy=0, no wr_strobe.
- Glitch rejection: a 2-cycle low pulse on SDA while SCL is high (FILTER_LEN=4) → no START detected; state stays IDLE.
- Collision: host_wr_en to reg5=0xFF in the same cycle as the bus write of 0x33 to reg5 → reg5=0x33.
